// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX (and planned TX) datapath.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS     = 8;
   localparam int unsigned DEFAULT_CLK_FREQ   = 100_000_000;
   localparam int unsigned DEFAULT_BAUD_RATE  = 115200;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

   // PARITY is always encoded so the state type is identical across builds.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every TICK_DIV clocks, phase reset by clear.
module uart_baud_tick #(
   parameter int unsigned TICK_DIV = 54
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = ~clear & (cnt_q == CNT_LAST);
      cnt_d = cnt_q + CW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_serial.sv
// 8N1 UART receiver with 16x oversampling; rx_data holds the last good byte.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_serial
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int unsigned TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_ready,
   output logic                      frame_error,
   output logic                      busy
);

   localparam int unsigned SCW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(UART_DATA_BITS);
   localparam logic [SCW-1:0] SAMPLE_MID  = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST    = BCW'(UART_DATA_BITS - 1);

   logic rx_meta_q, rx_s_q, rx_prev_q;
   logic start_edge, tick, tick_clear, frame_ok;

   rx_state_t state_q, state_d;
   logic [SCW-1:0] sample_cnt_q, sample_cnt_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic rx_ready_q, rx_ready_d;
   logic frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
   logic parity_err_q, parity_err_d;
`endif

   // Requiring a registered high before the low keeps a stuck-low line from re-triggering.
   assign start_edge = rx_prev_q & ~rx_s_q;
   assign tick_clear = (state_q == IDLE);

   uart_baud_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .clear(tick_clear),
      .tick (tick)
   );

   always_comb begin
      state_d       = state_q;
      sample_cnt_d  = sample_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_ready_d    = 1'b0;
      frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = parity_err_q;
      frame_ok      = rx_s_q & ~parity_err_q;
`else
      frame_ok      = rx_s_q;
`endif

      unique case (state_q)
         IDLE: begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
            if (start_edge) begin
               state_d = START;
            end
         end

         START: begin
            if (tick) begin
               if (sample_cnt_q == SAMPLE_MID) begin
                  sample_cnt_d = '0;
                  state_d      = rx_s_q ? IDLE : DATA;
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
         end

         // Sampling from the start-bit midpoint puts every later sample mid-bit.
         DATA: begin
            if (tick) begin
               if (sample_cnt_q == SAMPLE_LAST) begin
                  sample_cnt_d = '0;
                  shift_d      = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d   = PARITY;
`else
                     state_d   = STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + BCW'(1);
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (sample_cnt_q == SAMPLE_LAST) begin
                  sample_cnt_d = '0;
                  parity_err_d = (even_parity(shift_q) != rx_s_q);
                  state_d      = STOP;
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
         end
`endif

         // Decide at mid-stop so a following start bit is never missed.
         STOP: begin
            if (tick) begin
               if (sample_cnt_q == SAMPLE_LAST) begin
                  sample_cnt_d = '0;
                  state_d      = IDLE;
                  if (frame_ok) begin
                     rx_data_d  = shift_q;
                     rx_ready_d = 1'b1;
                  end else begin
                     frame_error_d = 1'b1;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         rx_prev_q     <= 1'b1;
         state_q       <= IDLE;
         sample_cnt_q  <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_ready_q    <= 1'b0;
         frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= 1'b0;
`endif
      end else begin
         rx_meta_q     <= rx;
         rx_s_q        <= rx_meta_q;
         rx_prev_q     <= rx_s_q;
         state_q       <= state_d;
         sample_cnt_q  <= sample_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_ready_q    <= rx_ready_d;
         frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_ready    = rx_ready_q;
   assign frame_error = frame_error_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_serial.sv
// Bench for uart_rx_serial: frames built bit-by-bit from byte values, pulses collected by a monitor.
module tb_uart_rx_serial;

   localparam int unsigned TD     = 4;
   localparam int unsigned OS     = 16;
   localparam int unsigned BIT    = TD * OS;
   localparam int unsigned LAT_LO = (19 * BIT) / 2 - TD;
   localparam int unsigned LAT_HI = (19 * BIT) / 2 + 2 * TD + 4;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_ready, frame_error, busy;

   always #5 clk = ~clk;

   uart_rx_serial #(
      .OVERSAMPLE(OS),
      .TICK_DIV  (TD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .frame_error(frame_error),
      .busy       (busy)
   );

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   int unsigned ferr_cnt = 0;
   int unsigned overlap_cnt = 0;
   int unsigned unstable_cnt = 0;
   logic [7:0]  got_data[$];
   int unsigned got_cyc[$];
   logic [7:0]  prev_data;

   always @(negedge clk) begin
      cyc++;
      if (rx_ready === 1'b1) begin
         got_data.push_back(rx_data);
         got_cyc.push_back(cyc);
      end
      if (frame_error === 1'b1) ferr_cnt++;
      if (rx_ready === 1'b1 && frame_error === 1'b1) overlap_cnt++;
      if (reset === 1'b0 && rx_ready !== 1'b1 && rx_data !== prev_data) unstable_cnt++;
      prev_data = rx_data;
   end

   task automatic clear_mon();
      got_data.delete();
      got_cyc.delete();
      ferr_cnt = 0;
   endtask

   task automatic idle_bits(input int unsigned n);
      rx = 1'b1;
      repeat (n * BIT) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int unsigned n);
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         rx = bits[i];
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
      send_bits({stop_b, ^d, d, 1'b0}, 11);
`else
      send_bits({1'b0, stop_b, d, 1'b0}, 10);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      total_cnt++;
      if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", rx_ready); else pass_cnt++;
      total_cnt++;
      if (frame_error !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_error); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      int unsigned lat;
      clear_mon();
      send_frame(8'h5A, 1'b1);
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 1) $display("FAIL single_count: got %0d want 1", got_data.size());
      else pass_cnt++;
      if (got_data.size() >= 1) begin
         total_cnt++;
         if (got_data[0] !== 8'h5A) $display("FAIL single_data: got %h want 5a", got_data[0]);
         else pass_cnt++;
         lat = got_cyc[0] - start_cyc;
         total_cnt++;
         if (lat < LAT_LO || lat > LAT_HI)
            $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_LO, LAT_HI);
         else pass_cnt++;
      end
      total_cnt++;
      if (ferr_cnt != 0) $display("FAIL single_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
      total_cnt++;
      if (rx_data !== 8'h5A) $display("FAIL single_hold: got %h want 5a", rx_data); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int unsigned gap;
      clear_mon();
      send_frame(8'h34, 1'b1);
      send_frame(8'h12, 1'b1);
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 2) $display("FAIL b2b_count: got %0d want 2", got_data.size());
      else pass_cnt++;
      if (got_data.size() == 2) begin
         total_cnt++;
         if (got_data[0] !== 8'h34) $display("FAIL b2b_first: got %h want 34", got_data[0]);
         else pass_cnt++;
         total_cnt++;
         if (got_data[1] !== 8'h12) $display("FAIL b2b_second: got %h want 12", got_data[1]);
         else pass_cnt++;
         gap = got_cyc[1] - got_cyc[0];
         total_cnt++;
         if (gap + 2 < FRAME_BITS * BIT || gap > FRAME_BITS * BIT + 2)
            $display("FAIL b2b_spacing: got %0d want %0d", gap, FRAME_BITS * BIT);
         else pass_cnt++;
      end
      total_cnt++;
      if (ferr_cnt != 0) $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0]  exp_q[$];
      logic [7:0]  d;
      logic [7:0]  last_good;
      logic        stop_b;
      int unsigned exp_ferr;
      clear_mon();
      exp_ferr  = 0;
      last_good = rx_data;
      for (int i = 0; i < 10; i++) begin
         d      = 8'($urandom);
         stop_b = ($urandom_range(0, 3) != 0);
         send_frame(d, stop_b);
         if (stop_b) begin
            exp_q.push_back(d);
            last_good = d;
            // Line may go straight into the next start bit.
            if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2));
         end else begin
            exp_ferr++;
            idle_bits($urandom_range(1, 2));
         end
      end
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != exp_q.size())
         $display("FAIL rand_count: got %0d want %0d", got_data.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         total_cnt++;
         if (got_data[i] !== exp_q[i])
            $display("FAIL rand_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (ferr_cnt != exp_ferr) $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt, exp_ferr);
      else pass_cnt++;
      total_cnt++;
      if (rx_data !== last_good) $display("FAIL rand_hold: got %h want %h", rx_data, last_good);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      repeat (2 * TD) @(negedge clk);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL glitch_busy_start: got %b want 1", busy); else pass_cnt++;
      repeat (2 * TD) @(negedge clk);
      idle_bits(2);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if (got_data.size() != 0) $display("FAIL glitch_ready: got %0d want 0", got_data.size());
      else pass_cnt++;
      total_cnt++;
      if (ferr_cnt != 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); else pass_cnt++;
   endtask

   task automatic test_frame_error();
      clear_mon();
      send_frame(8'hA5, 1'b1);
      idle_bits(1);
      send_frame(8'h66, 1'b0);
      repeat (3 * BIT) @(negedge clk);
      total_cnt++;
      if (ferr_cnt != 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt); else pass_cnt++;
      total_cnt++;
      if (got_data.size() != 1) $display("FAIL ferr_ready: got %0d want 1", got_data.size());
      else pass_cnt++;
      total_cnt++;
      if (rx_data !== 8'hA5) $display("FAIL ferr_hold: got %h want a5", rx_data); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL ferr_low_retrigger: got %b want 0", busy); else pass_cnt++;
      idle_bits(1);
      send_frame(8'h3C, 1'b1);
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 2) $display("FAIL ferr_recover_count: got %0d want 2", got_data.size());
      else pass_cnt++;
      total_cnt++;
      if (rx_data !== 8'h3C) $display("FAIL ferr_recover_data: got %h want 3c", rx_data);
      else pass_cnt++;
      total_cnt++;
      if (ferr_cnt != 1) $display("FAIL ferr_recover_ferr: got %0d want 1", ferr_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h5D;
      clear_mon();
      send_bits({d[2:0], 1'b0}, 4);
      rx = d[3];
      repeat (BIT / 2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (rx_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", rx_data); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b0 || frame_error !== 1'b0)
         $display("FAIL midrst_pulses: got %b%b want 00", rx_ready, frame_error);
      else pass_cnt++;
      reset = 1'b0;
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 0 || ferr_cnt != 0)
         $display("FAIL midrst_abort: got %0d/%0d want 0/0", got_data.size(), ferr_cnt);
      else pass_cnt++;
      send_frame(8'hC3, 1'b1);
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 1) $display("FAIL midrst_next_count: got %0d want 1", got_data.size());
      else pass_cnt++;
      total_cnt++;
      if (rx_data !== 8'hC3) $display("FAIL midrst_next_data: got %h want c3", rx_data);
      else pass_cnt++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_mon();
      send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
      idle_bits(2);
      total_cnt++;
      if (ferr_cnt != 1) $display("FAIL par_bad_ferr: got %0d want 1", ferr_cnt); else pass_cnt++;
      total_cnt++;
      if (got_data.size() != 0) $display("FAIL par_bad_ready: got %0d want 0", got_data.size());
      else pass_cnt++;
      send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
      idle_bits(2);
      total_cnt++;
      if (got_data.size() != 1) $display("FAIL par_good_ready: got %0d want 1", got_data.size());
      else pass_cnt++;
      total_cnt++;
      if (rx_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", rx_data); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      total_cnt++;
      if (overlap_cnt != 0) $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt);
      else pass_cnt++;
      total_cnt++;
      if (unstable_cnt != 0) $display("FAIL data_stability: got %0d want 0", unstable_cnt);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
